// File: rtl/mem_stage_sb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stage_sb_pkg                                                    |
// | Shared op-bit positions, load FSM states, memory-port owner codes   |
// | and the store byte-strobe helper for the MEM stage.                 |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package mem_stage_sb_pkg;

  localparam int LOAD_OP_W  = 7;
  localparam int STORE_OP_W = 4;

  // Load op one-hot bit positions: {lb,lbu,lh,lhu,lw,lwu,ld}
  localparam int LD_LB  = 6;
  localparam int LD_LBU = 5;
  localparam int LD_LH  = 4;
  localparam int LD_LHU = 3;
  localparam int LD_LW  = 2;
  localparam int LD_LWU = 1;
  localparam int LD_LD  = 0;

  // Store op one-hot bit positions: {sb,sh,sw,sd}
  localparam int ST_SB = 3;
  localparam int ST_SH = 2;
  localparam int ST_SW = 1;
  localparam int ST_SD = 0;

  typedef enum logic [1:0] {
    LS_IDLE = 2'd0,
    LS_REQ  = 2'd1,
    LS_RDW  = 2'd2,
    LS_DONE = 2'd3
  } load_state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_LOAD  = 2'd1,
    OWN_STORE = 2'd2
  } port_owner_t;

  // Byte enables for a store, computed at 64-bit lane width; RV32 users
  // keep the low four bits (sd never occurs there).
  function automatic logic [7:0] store_strobe(input logic [STORE_OP_W-1:0] op,
                                              input logic [2:0]            off);
    logic [7:0] s;
    s = 8'h00;
    if (op[ST_SB])      s = 8'h01 << off;
    else if (op[ST_SH]) s = 8'h03 << {off[2:1], 1'b0};
    else if (op[ST_SW]) s = 8'h0F << {off[2], 2'b00};
    else if (op[ST_SD]) s = 8'hFF;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_sb_store_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stage_sb_store_buffer                                           |
// | Posted-store FIFO with a per-entry word-address compare used to     |
// | detect load-after-store hazards against any pending entry.          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module mem_stage_sb_store_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq,
  input  logic [XLEN-1:0]   enq_addr,
  input  logic [XLEN-1:0]   enq_data,
  input  logic [XLEN/8-1:0] enq_strb,
  input  logic              deq,
  input  logic [XLEN-1:0]   cmp_addr,
  output logic [XLEN-1:0]   head_addr,
  output logic [XLEN-1:0]   head_data,
  output logic [XLEN/8-1:0] head_strb,
  output logic              full,
  output logic              empty,
  output logic              hazard
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [XLEN-1:0]   addr_mem [DEPTH];
  logic [XLEN-1:0]   data_mem [DEPTH];
  logic [XLEN/8-1:0] strb_mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  match;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W:0]    count;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_mem[head];
  assign head_data = data_mem[head];
  assign head_strb = strb_mem[head];
  assign hazard    = |match;

  // Every occupied entry, including the one currently being written out,
  // blocks a load to the same word.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match[i] = valid[i] && (addr_mem[i] == cmp_addr);
  end

  // Pointer, occupancy and per-entry valid bookkeeping; reset discards stores.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (enq) begin
        tail        <= tail + 1'b1;
        valid[tail] <= 1'b1;
      end
      if (deq) begin
        head        <= head + 1'b1;
        valid[head] <= 1'b0;
      end
      if (enq && !deq)      count <= count + 1'b1;
      else if (!enq && deq) count <= count - 1'b1;
    end
  end

  // Entry payload storage; contents are only meaningful while valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail] <= enq_addr;
      data_mem[tail] <= enq_data;
      strb_mem[tail] <= enq_strb;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_sb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stage_sb                                                        |
// | MEM pipeline stage (exe -> mem -> wb) with a posted store buffer,   |
// | one shared valid/ready memory port and ID-stage forwarding.         |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module mem_stage_sb
  import mem_stage_sb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [31:0]           in_pc,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_wdata,
  input  logic [LOAD_OP_W-1:0]  in_load_op,
  input  logic [STORE_OP_W-1:0] in_store_op,
  input  logic [4:0]            in_dest,
  input  logic                  in_rf_wen,
  input  logic                  wb_allowin,
  output logic                  mem_allowin,
  output logic                  out_valid,
  output logic [31:0]           out_pc,
  output logic [XLEN-1:0]       out_result,
  output logic [4:0]            out_dest,
  output logic                  out_rf_wen,
  output logic                  out_is_mem,
  output logic                  fw_valid,
  output logic                  fw_ready,
  output logic                  fw_is_load,
  output logic [4:0]            fw_dest,
  output logic [XLEN-1:0]       fw_data,
  output logic [XLEN-1:0]       mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic                  mem_req_ready,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [XLEN/8-1:0]     mem_wstrb,
  input  logic [XLEN-1:0]       rdata,
  input  logic                  rdata_valid,
  output logic                  rdata_ready,
  output logic                  sb_empty
);

  localparam int STRB = XLEN / 8;
  localparam int OFF  = $clog2(STRB);

  // Stage registers
  logic                  mem_valid;
  logic [31:0]           pc_q;
  logic [XLEN-1:0]       alu_q;
  logic [XLEN-1:0]       wdata_q;
  logic [LOAD_OP_W-1:0]  load_q;
  logic [STORE_OP_W-1:0] store_q;
  logic [4:0]            dest_q;
  logic                  rf_wen_q;

  logic                  is_load;
  logic                  is_store;
  logic                  ready_go;
  logic                  leave;
  logic                  load_entry;

  load_state_t           lstate;
  load_state_t           lstate_nxt;
  port_owner_t           owner;
  port_owner_t           owner_eff;
  logic [XLEN-1:0]       rdata_q;

  logic [XLEN-1:0]       word_addr;
  logic [STRB-1:0]       store_strb;
  logic [XLEN-1:0]       lane;
  logic [XLEN-1:0]       load_ext;

  logic                  sb_enq;
  logic                  sb_deq;
  logic                  sb_full;
  logic                  sb_hazard;
  logic [XLEN-1:0]       sb_head_addr;
  logic [XLEN-1:0]       sb_head_data;
  logic [STRB-1:0]       sb_head_strb;

  assign is_load    = |load_q;
  assign is_store   = |store_q;
  assign word_addr  = {alu_q[XLEN-1:OFF], {OFF{1'b0}}};
  assign store_strb = STRB'(store_strobe(store_q, 3'(alu_q[OFF-1:0])));

  // A store retires as soon as the buffer has room; a load only once its
  // data has been captured.
  assign ready_go    = is_load  ? (lstate == LS_DONE) :
                       is_store ? !sb_full : 1'b1;
  assign mem_allowin = !mem_valid || (ready_go && wb_allowin);
  assign out_valid   = mem_valid && ready_go;
  assign leave       = out_valid && wb_allowin;
  assign load_entry  = in_valid && mem_allowin && (|in_load_op);

  assign sb_enq      = mem_valid && is_store && !sb_full && wb_allowin;
  assign sb_deq      = (owner_eff == OWN_STORE) && mem_req_ready;

  // Stage registers capture a new instruction whenever the stage can accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      pc_q      <= '0;
      alu_q     <= '0;
      wdata_q   <= '0;
      load_q    <= '0;
      store_q   <= '0;
      dest_q    <= '0;
      rf_wen_q  <= 1'b0;
    end else begin
      if (mem_allowin) mem_valid <= in_valid;
      if (in_valid && mem_allowin) begin
        pc_q     <= in_pc;
        alu_q    <= in_alu_result;
        wdata_q  <= in_wdata;
        load_q   <= in_load_op;
        store_q  <= in_store_op;
        dest_q   <= in_dest;
        rf_wen_q <= in_rf_wen;
      end
    end
  end

  // Load FSM state register.
  always_ff @(posedge clk) begin
    if (rst) lstate <= LS_IDLE;
    else     lstate <= lstate_nxt;
  end

  // Load FSM next state; a load arriving as the previous one leaves goes
  // straight back to REQ.
  always_comb begin
    lstate_nxt  = lstate;
    rdata_ready = 1'b0;
    case (lstate)
      LS_IDLE: if (load_entry) lstate_nxt = LS_REQ;
      LS_REQ:  if (mem_read && mem_req_ready) lstate_nxt = LS_RDW;
      LS_RDW: begin
        rdata_ready = 1'b1;
        if (rdata_valid) lstate_nxt = LS_DONE;
      end
      LS_DONE: if (leave) lstate_nxt = load_entry ? LS_REQ : LS_IDLE;
      default: lstate_nxt = LS_IDLE;
    endcase
  end

  // Read data is held locally so the result stays stable while WB stalls.
  always_ff @(posedge clk) begin
    if (rst)                                   rdata_q <= '0;
    else if (lstate == LS_RDW && rdata_valid)  rdata_q <= rdata;
  end

  // Port arbitration: an unlocked port is granted combinationally (load
  // first, unless it hits a pending store), then locked until accepted.
  always_comb begin
    owner_eff = owner;
    if (owner == OWN_NONE) begin
      if (lstate == LS_REQ && !sb_hazard) owner_eff = OWN_LOAD;
      else if (!sb_empty)                 owner_eff = OWN_STORE;
    end
  end

  // Lock the owner while its request waits so it is never withdrawn.
  always_ff @(posedge clk) begin
    if (rst)                owner <= OWN_NONE;
    else if (mem_req_ready) owner <= OWN_NONE;
    else                    owner <= owner_eff;
  end

  assign mem_read  = (owner_eff == OWN_LOAD);
  assign mem_write = (owner_eff == OWN_STORE);
  assign mem_addr  = mem_read  ? word_addr :
                     mem_write ? sb_head_addr : '0;
  assign mem_wdata = mem_write ? sb_head_data : '0;
  assign mem_wstrb = mem_write ? sb_head_strb : '0;

  assign lane = rdata_q >> {alu_q[OFF-1:0], 3'b000};

  // Narrow the addressed lane to the load width with the right extension.
  always_comb begin
    load_ext = lane;
    if (load_q[LD_LB])       load_ext = XLEN'(signed'(lane[7:0]));
    else if (load_q[LD_LBU]) load_ext = XLEN'(lane[7:0]);
    else if (load_q[LD_LH])  load_ext = XLEN'(signed'(lane[15:0]));
    else if (load_q[LD_LHU]) load_ext = XLEN'(lane[15:0]);
    else if (load_q[LD_LW])  load_ext = XLEN'(signed'(lane[31:0]));
    else if (load_q[LD_LWU]) load_ext = XLEN'(lane[31:0]);
  end

  assign out_result = is_load ? load_ext : alu_q;
  assign out_pc     = pc_q;
  assign out_dest   = dest_q;
  assign out_rf_wen = rf_wen_q;
  assign out_is_mem = is_load || is_store;

  assign fw_valid   = mem_valid && rf_wen_q;
  assign fw_ready   = ready_go;
  assign fw_is_load = mem_valid && is_load;
  assign fw_dest    = dest_q;
  assign fw_data    = out_result;

  mem_stage_sb_store_buffer #(
    .XLEN  (XLEN),
    .DEPTH (SB_DEPTH)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .enq       (sb_enq),
    .enq_addr  (word_addr),
    .enq_data  (wdata_q),
    .enq_strb  (store_strb),
    .deq       (sb_deq),
    .cmp_addr  (word_addr),
    .head_addr (sb_head_addr),
    .head_data (sb_head_data),
    .head_strb (sb_head_strb),
    .full      (sb_full),
    .empty     (sb_empty),
    .hazard    (sb_hazard)
  );

endmodule
`default_nettype wire
